// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous input in clk cycles, rising edge to rising edge.
// Optional build macro PERIOD_METER_AVG_EN reports the truncated mean of the last 4 periods.
module period_meter #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 overflow,
    output logic                 locked
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt, cnt_d;
    logic [CNT_WIDTH-1:0]   period_d;
    logic                   valid_d;
    logic                   overflow_d;
    logic                   locked_d;

`ifdef PERIOD_METER_AVG_EN
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 2;
    logic [CNT_WIDTH-1:0] avg_h0, avg_h1, avg_h2;
    logic [CNT_WIDTH-1:0] avg_h0_d, avg_h1_d, avg_h2_d;
    logic [2:0]           avg_n, avg_n_d;
    logic [SUM_WIDTH-1:0] avg_sum;
`endif

    // Synchronizer chain plus history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            period       <= period_d;
            period_valid <= valid_d;
            overflow     <= overflow_d;
            locked       <= locked_d;
        end
    end

`ifdef PERIOD_METER_AVG_EN
    // Newest three completed periods; the current count is the fourth sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_h0 <= '0;
            avg_h1 <= '0;
            avg_h2 <= '0;
            avg_n  <= '0;
        end else begin
            avg_h0 <= avg_h0_d;
            avg_h1 <= avg_h1_d;
            avg_h2 <= avg_h2_d;
            avg_n  <= avg_n_d;
        end
    end

    assign avg_sum = SUM_WIDTH'(avg_h0) + SUM_WIDTH'(avg_h1)
                   + SUM_WIDTH'(avg_h2) + SUM_WIDTH'(cnt);
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        period_d   = period;
        valid_d    = 1'b0;
        overflow_d = overflow;
        locked_d   = locked;
`ifdef PERIOD_METER_AVG_EN
        avg_h0_d   = avg_h0;
        avg_h1_d   = avg_h1;
        avg_h2_d   = avg_h2;
        avg_n_d    = avg_n;
`endif
        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            locked_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_d = CNT_WIDTH'(1);
`ifdef PERIOD_METER_AVG_EN
                        avg_h0_d = cnt;
                        avg_h1_d = avg_h0;
                        avg_h2_d = avg_h1;
                        avg_n_d  = (avg_n >= 3'd4) ? 3'd4 : avg_n + 3'd1;
                        if (avg_n >= 3'd3) begin
                            period_d = CNT_WIDTH'(avg_sum >> 2);
                            valid_d  = 1'b1;
                            locked_d = 1'b1;
                        end
`else
                        period_d = cnt;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
`endif
                    end else if (cnt == CNT_MAX) begin
                        // Saturated without an edge: flag it and re-arm.
                        overflow_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = ARM;
                    end else begin
                        cnt_d = cnt + CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef PERIOD_METER_AVG_EN
        // History is only kept while measuring; leaving MEASURE discards it.
        if (state_d != MEASURE) begin
            avg_n_d = '0;
        end
`endif
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (CNT_WIDTH=8, SYNC_STAGES=2).
module tb_period_meter;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          overflow;
    logic          locked;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int base;
    logic [31:0] reps [0:255];

    period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .overflow     (overflow),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    // Record every reported period.
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            if (vcnt < 256) reps[vcnt] = 32'(period);
            vcnt = vcnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (hi) tick();
            sig_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
        repeat (3) tick();
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_locked", 32'(locked), 0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        repeat (2) tick();

`ifdef PERIOD_METER_AVG_EN
        // Measured periods 40, 40, 44, 44, then 48.
        base = vcnt;
        wave(20, 20, 2);
        wave(22, 22, 2);
        chk("avg_no_early", 32'(vcnt - base), 0);
        wave(24, 24, 2);
        chk("avg_count", 32'(vcnt - base), 2);
        chk("avg_first", reps[base], 42);
        chk("avg_second", reps[base+1], 44);
        chk("avg_locked", 32'(locked), 1);
`else
        // Steady 50-cycle square wave.
        base = vcnt;
        chk("pre_locked", 32'(locked), 0);
        wave(25, 25, 4);
        chk("steady_count", 32'(vcnt - base), 3);
        chk("steady_p0", reps[base], 50);
        chk("steady_p2", reps[base+2], 50);
        chk("steady_locked", 32'(locked), 1);

        // Switch to 20-cycle period at a rising edge.
        base = vcnt;
        wave(10, 10, 4);
        chk("chg_count", 32'(vcnt - base), 4);
        chk("chg_first", reps[base], 50);
        chk("chg_second", reps[base+1], 20);
        chk("chg_last", reps[base+3], 20);

        // Enable drop mid-period with an edge arriving while disabled.
        base = vcnt;
        en = 1'b0; sig_in = 1'b1;
        repeat (20) tick();
        chk("dis_count", 32'(vcnt - base), 0);
        chk("dis_period_hold", 32'(period), 20);
        chk("dis_locked", 32'(locked), 0);
        sig_in = 1'b0; en = 1'b1;
        repeat (5) tick();
        wave(25, 25, 1);
        chk("reen_one_edge", 32'(vcnt - base), 0);
        wave(25, 25, 1);
        chk("reen_two_edges", 32'(vcnt - base), 1);
        chk("reen_period", 32'(period), 50);

        // Overflow: one rising edge, then held low.
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (3) tick();
        base = vcnt;
        sig_in = 1'b1;
        repeat (5) tick();
        sig_in = 1'b0;
        repeat (252) tick();
        chk("ovf_before", 32'(overflow), 0);
        tick();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_locked", 32'(locked), 0);
        chk("ovf_no_valid", 32'(vcnt - base), 0);
        wave(5, 5, 3);
        chk("ovf_rec_count", 32'(vcnt - base), 2);
        chk("ovf_rec_period", 32'(period), 10);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_rec_locked", 32'(locked), 1);
        en = 1'b0;
        repeat (2) tick();
        chk("ovf_clr_by_en", 32'(overflow), 0);
        chk("ovf_hold_period", 32'(period), 10);
`endif

        // Asynchronous reset while measuring a 50-cycle input.
        en = 1'b1;
        repeat (3) tick();
        wave(25, 25, 3);
        sig_in = 1'b1;
        repeat (10) tick();
        chk("pre_rst_locked", 32'(locked), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_period", 32'(period), 0);
        chk("arst_valid", 32'(period_valid), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_locked", 32'(locked), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
